// File: rtl/pwm_led_driver.sv
// Multi-channel PWM LED driver: per-channel OFF / PWM / BLINK / BREATHE modes.
// Writes go to shadow registers and are loaded glitch-free at the period boundary.
//
// Ports:
//   clock_12mhz  - system clock, rising edge
//   reset        - synchronous active-low reset
//   wr_en        - one-cycle write strobe
//   wr_chan      - target channel (indices >= CHANNELS are ignored)
//   wr_mode      - 0=OFF 1=PWM 2=BLINK 3=BREATHE
//   wr_duty      - duty / blink length / breathe peak
//   period_start - one-cycle pulse aligned with period_cnt == 0
//   pwm_out      - registered channel outputs, inverted when ACTIVE_LOW
module pwm_led_driver #(
    parameter int CHANNELS     = 3,
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 46,
    parameter int BREATHE_STEP = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_12mhz,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [1:0]          wr_mode,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int SW = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_PWM     = 2'd1,
        M_BLINK   = 2'd2,
        M_BREATHE = 2'd3
    } mode_e;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick, boundary;

    mode_e            sh_mode_q  [CHANNELS];
    mode_e            sh_mode_d  [CHANNELS];
    logic [WIDTH-1:0] sh_duty_q  [CHANNELS];
    logic [WIDTH-1:0] sh_duty_d  [CHANNELS];
    mode_e            act_mode_q [CHANNELS];
    mode_e            act_mode_d [CHANNELS];
    logic [WIDTH-1:0] act_duty_q [CHANNELS];
    logic [WIDTH-1:0] act_duty_d [CHANNELS];
    logic [WIDTH-1:0] bcnt_q     [CHANNELS];
    logic [WIDTH-1:0] bcnt_d     [CHANNELS];
    logic             phase_q    [CHANNELS];
    logic             phase_d    [CHANNELS];
    logic [WIDTH-1:0] level_q    [CHANNELS];
    logic [WIDTH-1:0] level_d    [CHANNELS];
    logic             down_q     [CHANNELS];
    logic             down_d     [CHANNELS];
    logic [SW-1:0]    step_q     [CHANNELS];
    logic [SW-1:0]    step_d     [CHANNELS];

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] pwm_q;
    logic                ps_q;

    assign tick     = (presc_q == PW'(PRESCALE));
    assign boundary = tick && (cnt_q == {WIDTH{1'b1}});

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
        raw     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sh_mode_d[i]  = sh_mode_q[i];
            sh_duty_d[i]  = sh_duty_q[i];
            act_mode_d[i] = act_mode_q[i];
            act_duty_d[i] = act_duty_q[i];
            bcnt_d[i]     = bcnt_q[i];
            phase_d[i]    = phase_q[i];
            level_d[i]    = level_q[i];
            down_d[i]     = down_q[i];
            step_d[i]     = step_q[i];

            // Out-of-range channel indices never match any i.
            if (wr_en && (wr_chan == CW'(i))) begin
                sh_mode_d[i] = mode_e'(wr_mode);
                sh_duty_d[i] = wr_duty;
            end

            // Load reads the pre-write shadow, so a write on the
            // boundary cycle waits for the next boundary.
            if (boundary) begin
                act_mode_d[i] = sh_mode_q[i];
                act_duty_d[i] = sh_duty_q[i];
                if (sh_mode_q[i] != act_mode_q[i]) begin
                    bcnt_d[i]  = '0;
                    phase_d[i] = 1'b1;
                    level_d[i] = '0;
                    down_d[i]  = 1'b0;
                    step_d[i]  = '0;
                end else begin
                    if (bcnt_q[i] == sh_duty_q[i]) begin
                        bcnt_d[i]  = '0;
                        phase_d[i] = ~phase_q[i];
                    end else begin
                        bcnt_d[i] = bcnt_q[i] + 1'b1;
                    end
                    if (step_q[i] == SW'(BREATHE_STEP - 1)) begin
                        step_d[i] = '0;
                        if (!down_q[i]) begin
                            if (level_q[i] < sh_duty_q[i]) begin
                                level_d[i] = level_q[i] + 1'b1;
                            end else begin
                                // Peak reached (or duty lowered below level).
                                down_d[i] = 1'b1;
                                if (level_q[i] != '0)
                                    level_d[i] = level_q[i] - 1'b1;
                            end
                        end else begin
                            if (level_q[i] != '0) begin
                                level_d[i] = level_q[i] - 1'b1;
                            end else if (sh_duty_q[i] != '0) begin
                                down_d[i]  = 1'b0;
                                level_d[i] = WIDTH'(1);
                            end
                        end
                    end else begin
                        step_d[i] = step_q[i] + 1'b1;
                    end
                end
            end

            unique case (act_mode_q[i])
                M_OFF:     raw[i] = 1'b0;
                M_PWM:     raw[i] = cnt_q < act_duty_q[i];
                M_BLINK:   raw[i] = phase_q[i];
                M_BREATHE: raw[i] = cnt_q < level_q[i];
            endcase
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (!reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            ps_q    <= 1'b0;
            pwm_q   <= {CHANNELS{ACTIVE_LOW}};
            for (int i = 0; i < CHANNELS; i++) begin
                sh_mode_q[i]  <= M_OFF;
                sh_duty_q[i]  <= '0;
                act_mode_q[i] <= M_OFF;
                act_duty_q[i] <= '0;
                bcnt_q[i]     <= '0;
                phase_q[i]    <= 1'b0;
                level_q[i]    <= '0;
                down_q[i]     <= 1'b0;
                step_q[i]     <= '0;
            end
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ps_q    <= boundary;
            pwm_q   <= raw ^ {CHANNELS{ACTIVE_LOW}};
            for (int i = 0; i < CHANNELS; i++) begin
                sh_mode_q[i]  <= sh_mode_d[i];
                sh_duty_q[i]  <= sh_duty_d[i];
                act_mode_q[i] <= act_mode_d[i];
                act_duty_q[i] <= act_duty_d[i];
                bcnt_q[i]     <= bcnt_d[i];
                phase_q[i]    <= phase_d[i];
                level_q[i]    <= level_d[i];
                down_q[i]     <= down_d[i];
                step_q[i]     <= step_d[i];
            end
        end
    end

    assign period_start = ps_q;
    assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_pwm_led_driver.sv
// Directed bench for pwm_led_driver: reset, PWM, shadow timing, blink,
// breathe, illegal channel and mid-run reset, counted per PWM period.
module tb_pwm_led_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_chan;
    logic [1:0] wr_mode;
    logic [7:0] wr_duty;
    logic       ps;
    logic [2:0] pwm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_led_driver #(
        .CHANNELS    (3),
        .WIDTH       (8),
        .PRESCALE    (0),
        .BREATHE_STEP(1),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clock_12mhz (clk),
        .reset       (rst_n),
        .wr_en       (wr_en),
        .wr_chan     (wr_chan),
        .wr_mode     (wr_mode),
        .wr_duty     (wr_duty),
        .period_start(ps),
        .pwm_out     (pwm)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for period_start, then counts low (LED on) cycles per channel
    // over the following 256 cycles; optionally writes at cycle index 'at'.
    task automatic period(input bit do_wr, input int at,
                          input logic [1:0] ch, input logic [1:0] md,
                          input logic [7:0] du,
                          output int l0, output int l1, output int l2);
        int n = 0;
        while (ps !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("period_start_seen", int'(ps === 1'b1), 1);
        l0 = 0;
        l1 = 0;
        l2 = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (pwm[0] === 1'b0) l0++;
            if (pwm[1] === 1'b0) l1++;
            if (pwm[2] === 1'b0) l2++;
            wr_en   = do_wr && (i == at);
            wr_chan = ch;
            wr_mode = md;
            wr_duty = du;
        end
        wr_en = 1'b0;
    endtask

    task automatic count_to_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps !== 1'b1 && n < 600);
    endtask

    initial begin
        int a, b, c, n;
        int exp_blink [7] = '{256, 256, 256, 0, 0, 0, 256};
        int exp_br    [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_chan = '0;
        wr_mode = '0;
        wr_duty = '0;

        // Reset hold
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_pwm", int'(pwm), 7);
            chk("rst_ps", int'(ps), 0);
        end
        rst_n = 1'b1;
        count_to_ps(n);
        chk("first_ps_latency", n, 256);
        chk("off_after_rst", int'(pwm), 7);

        // PWM duty 64 / 0 / 255 on ch0
        period(1'b1, 1, 2'd0, 2'd1, 8'd64, a, b, c);
        chk("ch0_off_before_load", a, 0);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("ch0_pwm64", a, 64);
        period(1'b1, 10, 2'd0, 2'd1, 8'd0, a, b, c);
        chk("ch0_pwm64_shadowed", a, 64);
        period(1'b1, 10, 2'd0, 2'd1, 8'd255, a, b, c);
        chk("ch0_pwm0", a, 0);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("ch0_pwm255", a, 255);

        // Shadow timing on ch1
        period(1'b1, 5, 2'd1, 2'd1, 8'd64, a, b, c);
        chk("ch1_off_before_load", b, 0);
        period(1'b1, 100, 2'd1, 2'd1, 8'd200, a, b, c);
        chk("ch1_midwrite_keeps64", b, 64);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("ch1_pwm200", b, 200);
        period(1'b1, 255, 2'd1, 2'd1, 8'd30, a, b, c);
        chk("ch1_bwrite_p0", b, 200);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("ch1_bwrite_p1", b, 200);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("ch1_bwrite_p2", b, 30);

        // Illegal channel index
        period(1'b1, 1, 2'd3, 2'd0, 8'd0, a, b, c);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("illegal_ch0", a, 255);
        chk("illegal_ch1", b, 30);
        chk("illegal_ch2", c, 0);

        // Blink ch2 duty 2
        period(1'b1, 1, 2'd2, 2'd2, 8'd2, a, b, c);
        chk("ch2_off_before_blink", c, 0);
        for (int k = 0; k < 7; k++) begin
            period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
            chk($sformatf("blink_p%0d", k), c, exp_blink[k]);
        end

        // Breathe ch0 duty 4, then switch to PWM and back
        period(1'b1, 1, 2'd0, 2'd3, 8'd4, a, b, c);
        chk("ch0_pwm_before_breathe", a, 255);
        for (int k = 0; k < 10; k++) begin
            period(k == 9, 1, 2'd0, 2'd1, 8'd100, a, b, c);
            chk($sformatf("breathe_p%0d", k), a, exp_br[k]);
        end
        period(1'b1, 1, 2'd0, 2'd3, 8'd4, a, b, c);
        chk("breathe_to_pwm100", a, 100);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("rebreathe_p0", a, 0);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("rebreathe_p1", a, 1);

        // Reset mid-breathe
        for (int i = 0; i < 50; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_pwm", int'(pwm), 7);
        chk("abort_ps", int'(ps), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_to_ps(n);
        chk("abort_ps_latency", n, 256);
        period(1'b0, 0, 2'd0, 2'd0, 8'd0, a, b, c);
        chk("abort_ch0_off", a, 0);
        chk("abort_ch1_off", b, 0);
        chk("abort_ch2_off", c, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
